// File: rtl/instr_cache_if.sv
// Word-wide request/valid port between the instruction cache and instruction memory.
// The cache is the master and holds the address until the memory returns a word.
interface instr_cache_if #(
    parameter int WIDTH = 32
);
    logic             mem_req;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_rvalid;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_rdata,
        input  mem_rvalid
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_rdata,
        output mem_rvalid
    );
endinterface

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache with a combinational hit path,
// word-by-word line refill over a req/valid memory port and fence.i invalidate.
module instr_cache #(
    parameter int WIDTH = 32,
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] PC,
    input  logic             Invalidate,
    output logic [WIDTH-1:0] Instr,
    output logic             InstrValid,
    output logic             Stall,
    instr_cache_if.master    mem
);

    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = WIDTH - IDX_W - OFF_W - 2;

    localparam logic [WIDTH-1:0] NOP       = WIDTH'(32'h0000_0013);
    localparam logic [OFF_W-1:0] BEAT_ONE  = OFF_W'(1);
    localparam logic [OFF_W-1:0] BEAT_LAST = OFF_W'(WORDS - 1);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_REFILL = 1'b1
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [WIDTH-1:0] r_data [LINES][WORDS];
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [LINES-1:0] r_valid;

    // Line being refilled, latched at the miss so PC is free to wander meanwhile.
    logic [TAG_W-1:0] r_tag_l;
    logic [IDX_W-1:0] r_idx_l;
    logic [OFF_W-1:0] r_beat;
    logic             r_abort;

    logic [OFF_W-1:0] w_off;
    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_hit;
    logic             w_refill_start;
    logic             w_refill_done;
    logic             w_beat_accept;
    logic             w_unused_pc;

    assign w_off       = PC[OFF_W+1:2];
    assign w_idx       = PC[IDX_W+OFF_W+1:OFF_W+2];
    assign w_tag       = PC[WIDTH-1:IDX_W+OFF_W+2];
    assign w_unused_pc = &{1'b0, PC[1:0]};

    assign w_hit         = (r_state == S_IDLE) && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_beat_accept = (r_state == S_REFILL) && mem.mem_rvalid;

    // Outputs are forced quiet while rst is high, since an empty cache would otherwise report a miss.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_next_state   = r_state;
        w_refill_start = 1'b0;
        w_refill_done  = 1'b0;
        Instr          = NOP;
        InstrValid     = 1'b0;
        Stall          = 1'b0;
        mem.mem_req    = 1'b0;
        mem.mem_addr   = {r_tag_l, r_idx_l, r_beat, 2'b00};

        if (!rst) begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_hit) begin
                        Instr      = r_data[w_idx][w_off];
                        InstrValid = 1'b1;
                    end else begin
                        Stall          = 1'b1;
                        w_refill_start = 1'b1;
                        w_next_state   = S_REFILL;
                    end
                end
                S_REFILL: begin
                    Stall       = 1'b1;
                    mem.mem_req = 1'b1;
                    if (mem.mem_rvalid && (r_beat == BEAT_LAST)) begin
                        w_refill_done = 1'b1;
                        w_next_state  = S_IDLE;
                    end
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_tag_l <= '0;
            r_idx_l <= '0;
            r_beat  <= '0;
            r_abort <= 1'b0;
        end else begin
            if (w_refill_start) begin
                r_tag_l <= w_tag;
                r_idx_l <= w_idx;
                r_beat  <= '0;
                r_abort <= 1'b0;
            end else if (r_state == S_REFILL) begin
                if (mem.mem_rvalid) begin
                    r_beat <= r_beat + BEAT_ONE;
                end
                if (Invalidate) begin
                    r_abort <= 1'b1;
                end
            end

            // Invalidate wins over a line completing on the same edge.
            if (Invalidate) begin
                r_valid <= '0;
            end else if (w_refill_done) begin
                r_valid[r_idx_l] <= ~r_abort;
            end
        end
    end

    // NOTE: data and tag arrays carry no reset; the valid bits alone decide whether their contents are used.
    always_ff @(posedge clk) begin
        if (w_beat_accept) begin
            r_data[r_idx_l][r_beat] <= mem.mem_rdata;
        end
        if (w_refill_done) begin
            r_tag[r_idx_l] <= r_tag_l;
        end
    end

endmodule

// File: tb/tb_instr_cache.sv
// Directed bench for instr_cache: memory returns address+0x100 for every word,
// with a per-scenario response rate and invalidate/reset injection points.
module tb_instr_cache;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        inv;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic        stall;

    int n_checks = 0;
    int n_fail   = 0;

    instr_cache_if #(.WIDTH(32)) mif ();

    instr_cache #(
        .WIDTH(32),
        .LINES(16),
        .WORDS(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .PC         (pc),
        .Invalidate (inv),
        .Instr      (instr),
        .InstrValid (instr_valid),
        .Stall      (stall),
        .mem        (mif)
    );

    always #5 clk = ~clk;

    assign mif.mem_rdata = mif.mem_addr + 32'h100;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one refill from the current miss cycle until the cycle after the last beat.
    // A word is returned on every period-th request cycle; inv_beat >= 0 pulses Invalidate once in that beat.
    task automatic refill(input string name, input logic [31:0] base, input int period,
                          input int inv_beat, input int exp_stall);
        int stalls = 0;
        int beats = 0;
        int req_cycles = 0;
        int addr_err = 0;
        int guard = 0;
        bit inv_done = 0;
        while (beats < 4 && guard < 200) begin
            guard++;
            if (stall === 1'b1) stalls++;
            if (mif.mem_req === 1'b1) begin
                if (mif.mem_addr !== base + 32'(4 * beats)) addr_err++;
                req_cycles++;
                if (beats == inv_beat && !inv_done) begin
                    inv = 1'b1;
                    inv_done = 1'b1;
                end
                mif.mem_rvalid = ((req_cycles % period) == 0);
                if (mif.mem_rvalid) beats++;
            end else begin
                mif.mem_rvalid = 1'b0;
            end
            @(posedge clk);
            #1;
            mif.mem_rvalid = 1'b0;
            inv = 1'b0;
            #1;
        end
        n_checks++; if (beats != 4) begin n_fail++; $display("FAIL %s_beats: got %0d expected 4 (timeout)", name, beats); end
        n_checks++; if (stalls != exp_stall) begin n_fail++; $display("FAIL %s_stall_cycles: got %0d expected %0d", name, stalls, exp_stall); end
        n_checks++; if (addr_err != 0) begin n_fail++; $display("FAIL %s_mem_addr: got %0d bad cycles expected 0", name, addr_err); end
    endtask

    task automatic test_reset();
        rst = 1'b1; inv = 1'b0; pc = 32'h0; mif.mem_rvalid = 1'b0;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
        n_checks++; if (mif.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b expected 0", mif.mem_req); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
        n_checks++; if (instr !== NOP) begin n_fail++; $display("FAIL reset_instr: got %h expected %h", instr, NOP); end
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_first_fill();
        pc = 32'h0;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL t1_miss_stall: got %b expected 1", stall); end
        refill("t1", 32'h0, 1, -1, 5);
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL t1_stall_after: got %b expected 0", stall); end
        n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL t1_valid: got %b expected 1", instr_valid); end
        n_checks++; if (instr !== 32'h100) begin n_fail++; $display("FAIL t1_instr: got %h expected 00000100", instr); end
    endtask

    task automatic test_hits();
        logic [31:0] addrs [3];
        addrs[0] = 32'h4; addrs[1] = 32'h8; addrs[2] = 32'hC;
        for (int i = 0; i < 3; i++) begin
            step();
            pc = addrs[i];
            #1;
            n_checks++; if (instr !== addrs[i] + 32'h100) begin n_fail++; $display("FAIL t2_instr_%0d: got %h expected %h", i, instr, addrs[i] + 32'h100); end
            n_checks++; if ({stall, mif.mem_req, instr_valid} !== 3'b001) begin n_fail++; $display("FAIL t2_ctrl_%0d: got %b expected 001", i, {stall, mif.mem_req, instr_valid}); end
        end
    endtask

    task automatic test_conflict();
        step(); pc = 32'h100; #1;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL t3_miss: got %b expected 1", stall); end
        refill("t3a", 32'h100, 1, -1, 5);
        n_checks++; if (instr !== 32'h200) begin n_fail++; $display("FAIL t3_instr_new: got %h expected 00000200", instr); end
        step(); pc = 32'h108; #1;
        n_checks++; if (instr !== 32'h208 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL t3_hit_108: got %h/%b expected 00000208/1", instr, instr_valid); end
        step(); pc = 32'h0; #1;
        n_checks++; if (stall !== 1'b1 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL t3_evicted: got stall %b valid %b expected 1 0", stall, instr_valid); end
        refill("t3b", 32'h0, 1, -1, 5);
        n_checks++; if (instr !== 32'h100) begin n_fail++; $display("FAIL t3_instr_old: got %h expected 00000100", instr); end
    endtask

    task automatic test_wait_states();
        step(); pc = 32'h24; #1;
        refill("t4", 32'h20, 3, -1, 13);
        n_checks++; if (instr !== 32'h124 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL t4_instr: got %h/%b expected 00000124/1", instr, instr_valid); end
        step(); pc = 32'h2C; #1;
        n_checks++; if (instr !== 32'h12C || stall !== 1'b0) begin n_fail++; $display("FAIL t4_hit_2c: got %h/%b expected 0000012c/0", instr, stall); end
    endtask

    task automatic test_invalidate();
        step(); pc = 32'h0; inv = 1'b1; #1;
        n_checks++; if (instr_valid !== 1'b1 || instr !== 32'h100) begin n_fail++; $display("FAIL t5_same_cycle: got %h/%b expected 00000100/1", instr, instr_valid); end
        step(); inv = 1'b0; #1;
        n_checks++; if (stall !== 1'b1 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL t5_idle_inv_miss: got stall %b valid %b expected 1 0", stall, instr_valid); end
        refill("t5a", 32'h0, 1, -1, 5);
        n_checks++; if (instr !== 32'h100) begin n_fail++; $display("FAIL t5a_instr: got %h expected 00000100", instr); end

        step(); pc = 32'h30; #1;
        refill("t5b", 32'h30, 1, 2, 5);
        n_checks++; if ({stall, mif.mem_req, instr_valid} !== 3'b100) begin n_fail++; $display("FAIL t5b_abort_miss: got %b expected 100", {stall, mif.mem_req, instr_valid}); end
        refill("t5c", 32'h30, 1, -1, 5);
        n_checks++; if (instr !== 32'h130 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL t5c_instr: got %h/%b expected 00000130/1", instr, instr_valid); end

        step(); pc = 32'h50; #1;
        refill("t5d", 32'h50, 1, 3, 5);
        n_checks++; if (stall !== 1'b1 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL t5d_last_beat_inv: got stall %b valid %b expected 1 0", stall, instr_valid); end
        refill("t5e", 32'h50, 1, -1, 5);
        n_checks++; if (instr !== 32'h150) begin n_fail++; $display("FAIL t5e_instr: got %h expected 00000150", instr); end
    endtask

    task automatic test_reset_mid_refill();
        step(); pc = 32'h0; #1;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL t6_miss: got %b expected 1", stall); end
        step(); mif.mem_rvalid = 1'b1; #1;
        n_checks++; if (mif.mem_req !== 1'b1 || mif.mem_addr !== 32'h0) begin n_fail++; $display("FAIL t6_beat0: got %b/%h expected 1/00000000", mif.mem_req, mif.mem_addr); end
        step(); mif.mem_rvalid = 1'b0; #1;
        n_checks++; if (mif.mem_req !== 1'b1 || mif.mem_addr !== 32'h4) begin n_fail++; $display("FAIL t6_beat1: got %b/%h expected 1/00000004", mif.mem_req, mif.mem_addr); end
        rst = 1'b1; #1;
        n_checks++; if (mif.mem_req !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL t6_rst_quiet: got req %b stall %b expected 0 0", mif.mem_req, stall); end
        n_checks++; if (instr !== NOP || instr_valid !== 1'b0) begin n_fail++; $display("FAIL t6_rst_instr: got %h/%b expected 00000013/0", instr, instr_valid); end
        step(); step(); rst = 1'b0; #1;
        n_checks++; if (stall !== 1'b1 || mif.mem_req !== 1'b0) begin n_fail++; $display("FAIL t6_restart_miss: got stall %b req %b expected 1 0", stall, mif.mem_req); end
        refill("t6", 32'h0, 1, -1, 5);
        n_checks++; if (instr !== 32'h100 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL t6_instr: got %h/%b expected 00000100/1", instr, instr_valid); end
    endtask

    initial begin
        test_reset();
        test_first_fill();
        test_hits();
        test_conflict();
        test_wait_states();
        test_invalidate();
        test_reset_mid_refill();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

endmodule
